// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one write port, a pending-write
// scoreboard and a sequential clear FSM. Define RF_BYPASS_EN for write-to-read forwarding.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_req,
  output logic            clr_busy,
  input  logic [AW-1:0]   pr1,
  input  logic [AW-1:0]   pr2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rdy1,
  output logic            rdy2,
  input  logic            we,
  input  logic [AW-1:0]   wr,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_wr_fire;
  logic            w_iss_fire;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_rdy1;
  logic            w_rdy2;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ZERO_A   = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  assign w_wr_fire  = we && (wr != ZERO_A) && (r_state == ST_IDLE);
  assign w_iss_fire = iss_valid && (iss_rd != ZERO_A) && (r_state == ST_IDLE);
  assign clr_busy   = (r_state == ST_CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= ONE_A;
      r_pend  <= {NREG{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
        w_idx_nxt = ONE_A;
      end
      ST_CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = ONE_A;
        end else begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = r_idx + ONE_A;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = ONE_A;
      end
    endcase
  end

  // Clear before set: a same-cycle issue is the newer producer and must win.
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_state == ST_CLEAR) begin
      w_pend_nxt[r_idx] = 1'b0;
    end else begin
      if (w_wr_fire) begin
        w_pend_nxt[wr] = 1'b0;
      end else begin
        w_pend_nxt = w_pend_nxt;
      end
      if (w_iss_fire) begin
        w_pend_nxt[iss_rd] = 1'b1;
      end else begin
        w_pend_nxt = w_pend_nxt;
      end
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= {XLEN{1'b0}};
      end
    end else if (r_state == ST_CLEAR) begin
      r_rf[r_idx] <= {XLEN{1'b0}};
    end else if (w_wr_fire) begin
      r_rf[wr] <= wd;
    end
  end

  // Read ports; decode is stalled on both ports while the clear runs.
  always_comb begin
    w_rd1  = (pr1 == ZERO_A) ? {XLEN{1'b0}} : r_rf[pr1];
    w_rd2  = (pr2 == ZERO_A) ? {XLEN{1'b0}} : r_rf[pr2];
    w_rdy1 = 1'b0;
    w_rdy2 = 1'b0;
    if (r_state == ST_IDLE) begin
      w_rdy1 = (pr1 == ZERO_A) ? 1'b1 : ~r_pend[pr1];
      w_rdy2 = (pr2 == ZERO_A) ? 1'b1 : ~r_pend[pr2];
    end else begin
      w_rdy1 = 1'b0;
      w_rdy2 = 1'b0;
    end
`ifdef RF_BYPASS_EN
    if (w_wr_fire && (wr == pr1)) begin
      w_rd1  = wd;
      w_rdy1 = 1'b1;
    end else begin
      w_rd1 = w_rd1;
    end
    if (w_wr_fire && (wr == pr2)) begin
      w_rd2  = wd;
      w_rdy2 = 1'b1;
    end else begin
      w_rd2 = w_rd2;
    end
`endif
  end

  assign rd1  = w_rd1;
  assign rd2  = w_rd2;
  assign rdy1 = w_rdy1;
  assign rdy2 = w_rdy2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default and RF_BYPASS_EN builds).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr_req;
  logic        clr_busy;
  logic [4:0]  pr1, pr2;
  logic [31:0] rd1, rd2;
  logic        rdy1, rdy2;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;

  int errors = 0;
  int checks = 0;

  reg_file_sb #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .pr1(pr1), .pr2(pr2), .rd1(rd1), .rd2(rd2), .rdy1(rdy1), .rdy2(rdy2),
    .we(we), .wr(wr), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wr = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] a);
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = a;
    @(posedge clk); #1;
    iss_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clr_req = 1'b0; we = 1'b0; wr = 5'd0; wd = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; pr1 = 5'd0; pr2 = 5'd0;
    #12;
    checks++;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
    for (int i = 0; i < 32; i++) begin
      pr1 = 5'(i); pr2 = 5'(31 - i); #1;
      checks++;
      if (rd1 !== 32'd0 || rdy1 !== 1'b1 || rd2 !== 32'd0 || rdy2 !== 1'b1) begin
        errors++;
        $display("FAIL reset_read r%0d got rd1=%h rdy1=%b rd2=%h rdy2=%b exp 0/1", i, rd1, rdy1, rd2, rdy2);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_r0;
    do_write(5'd0, 32'hFFFF_FFFF);
    do_issue(5'd0);
    pr1 = 5'd0; #1;
    checks++;
    if (rd1 !== 32'd0 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL r0_hardwired got rd1=%h rdy1=%b exp 0/1", rd1, rdy1);
    end
  endtask

  task automatic test_write;
    @(negedge clk);
    we = 1'b1; wr = 5'd5; wd = 32'hDEAD_BEEF; pr1 = 5'd5; pr2 = 5'd5; #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_same_cycle got=%h exp=deadbeef", rd1); end
`else
    if (rd1 !== 32'd0) begin errors++; $display("FAIL write_same_cycle got=%h exp=0", rd1); end
`endif
    @(posedge clk); #1;
    we = 1'b0; #1;
    checks++;
    if (rd1 !== 32'hDEAD_BEEF || rd2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_next_cycle got rd1=%h rd2=%h exp=deadbeef", rd1, rd2);
    end
  endtask

  task automatic test_scoreboard;
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7; pr1 = 5'd7; pr2 = 5'd6; #1;
    checks++;
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL sb_before_edge got=%b exp=1", rdy1); end
    @(posedge clk); #1;
    iss_valid = 1'b0; #1;
    checks++;
    if (rdy1 !== 1'b0 || rdy2 !== 1'b1) begin
      errors++; $display("FAIL sb_pending got rdy1=%b rdy2=%b exp 0/1", rdy1, rdy2);
    end
    @(negedge clk);
    we = 1'b1; wr = 5'd7; wd = 32'h0000_0077; #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL sb_wb_cycle got=%b exp=1", rdy1); end
`else
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL sb_wb_cycle got=%b exp=0", rdy1); end
`endif
    @(posedge clk); #1;
    we = 1'b0; #1;
    checks++;
    if (rdy1 !== 1'b1 || rd1 !== 32'h0000_0077) begin
      errors++; $display("FAIL sb_after_wb got rdy1=%b rd1=%h exp 1/77", rdy1, rd1);
    end
  endtask

  task automatic test_same_cycle;
    do_issue(5'd9);
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; wr = 5'd9; wd = 32'h0000_0099;
    @(posedge clk); #1;
    iss_valid = 1'b0; we = 1'b0; pr1 = 5'd9; #1;
    checks++;
    if (rd1 !== 32'h0000_0099 || rdy1 !== 1'b0) begin
      errors++; $display("FAIL same_cycle_set_wins got rd1=%h rdy1=%b exp 99/0", rd1, rdy1);
    end
  endtask

  task automatic test_clear;
    int busy_cnt;
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    do_issue(5'd12);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0; pr1 = 5'd5; pr2 = 5'd31;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (clr_busy !== 1'b1) break;
      busy_cnt++;
      we = 1'b1; wr = 5'd20; wd = 32'hFFFF_0000; iss_valid = 1'b1; iss_rd = 5'd21;
      #1;
      if (busy_cnt == 1) begin
        checks++;
        if (rd2 !== 32'd31 || rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
          errors++; $display("FAIL clear_first_cycle got rd2=%h rdy1=%b rdy2=%b exp 1f/0/0", rd2, rdy1, rdy2);
        end
      end
    end
    we = 1'b0; iss_valid = 1'b0;
    checks++;
    if (busy_cnt != 31) begin errors++; $display("FAIL clear_busy_len got=%0d exp=31", busy_cnt); end
    for (int i = 0; i < 32; i++) begin
      pr1 = 5'(i); pr2 = 5'(i); #1;
      checks++;
      if (rd1 !== 32'd0 || rdy1 !== 1'b1 || rdy2 !== 1'b1) begin
        errors++; $display("FAIL clear_result r%0d got rd1=%h rdy1=%b rdy2=%b exp 0/1/1", i, rd1, rdy1, rdy2);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    do_write(5'd5, 32'd55);
    do_write(5'd31, 32'd31);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    pr1 = 5'd5; pr2 = 5'd31; #1;
    checks++;
    if (clr_busy !== 1'b1 || rd1 !== 32'd0 || rd2 !== 32'd31) begin
      errors++; $display("FAIL mid_clear_partial got busy=%b rd1=%h rd2=%h exp 1/0/1f", clr_busy, rd1, rd2);
    end
    reset_n = 1'b0; #1;
    checks++;
    if (clr_busy !== 1'b0 || rd2 !== 32'd0 || rdy1 !== 1'b1 || rdy2 !== 1'b1) begin
      errors++; $display("FAIL mid_clear_reset got busy=%b rd2=%h rdy=%b%b exp 0/0/11", clr_busy, rd2, rdy1, rdy2);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    checks++;
    if (clr_busy !== 1'b1) begin errors++; $display("FAIL clear_after_reset got=%b exp=1", clr_busy); end
    for (int c = 0; c < 100 && clr_busy === 1'b1; c++) @(posedge clk);
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_after_reset_done got=%b exp=0", clr_busy); end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_write();
    test_scoreboard();
    test_same_cycle();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
